// File: rtl/controle_paridade.sv
// controle_paridade
//   Frame-level parity controller. Words of WIDTH bits arrive over a
//   valid/ready handshake. Parity is accumulated over FRAME_LEN words, and the
//   frame result is presented over a second valid/ready handshake.
//
//   Optional feature macro: PARIDADE_CHECK_EN
//     defined   : exp_parity is registered with the last word of the frame and
//                 res_mismatch reports res_parity != exp_parity.
//     undefined : exp_parity is ignored and res_mismatch is tied to 0.
//
//   Ports
//     clk, rst      rising-edge clock, synchronous active-high reset
//     clear         synchronous frame abort (drops partial frame and result)
//     in_data       input word
//     in_valid      word offered
//     in_ready      controller can take a word
//     exp_parity    expected frame parity, sampled with the last word
//     res_valid     frame result available
//     res_ready     consumer takes the result
//     res_parity    frame parity (XOR of all bits, inverted when ODD_MODE=1)
//     res_odd_cnt   number of odd-parity words in the frame
//     res_mismatch  res_parity differs from the sampled exp_parity
//     busy          frame in progress or result pending
//
//   state  | meaning
//   IDLE   | no frame in progress, accumulators at zero
//   ACCUM  | at least one word of the frame taken, waiting for the rest
//   REPORT | result held on res_*, waiting for res_ready
module controle_paridade #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned ODD_MODE  = 0,
  localparam int unsigned CW       = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             exp_parity,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_parity,
  output logic [CW-1:0]    res_odd_cnt,
  output logic             res_mismatch,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic ODD_BIT = (ODD_MODE != 0);

  state_t        state_q;
  state_t        state_d;
  logic          acc_q;
  logic [CW-1:0] odd_q;
  logic [CW-1:0] cnt_q;
  logic          res_par_q;
  logic [CW-1:0] res_cnt_q;

  logic          wp;
  logic          take;
  logic          last_word;
  logic          res_take;
  logic [CW-1:0] odd_next;

  assign wp        = ^in_data;
  assign in_ready  = (state_q != REPORT) && !clear && !rst;
  assign take      = in_valid && in_ready;
  assign last_word = take && (cnt_q == CW'(FRAME_LEN - 1));
  assign res_take  = (state_q == REPORT) && res_ready;

  // The count can never pass FRAME_LEN within one frame; the guard keeps the
  // output bounded even if the counter were ever disturbed.
  assign odd_next = (wp && (odd_q != CW'(FRAME_LEN))) ? odd_q + CW'(1) : odd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          state_d = last_word ? REPORT : ACCUM;
        end
      end
      ACCUM: begin
        if (last_word) begin
          state_d = REPORT;
        end
      end
      REPORT: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
    end
  end

  // Accumulators restart at zero on the last word, so a frame begun in IDLE
  // and one continued in ACCUM share the same update path.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_q     <= 1'b0;
      odd_q     <= '0;
      cnt_q     <= '0;
      res_par_q <= 1'b0;
      res_cnt_q <= '0;
    end else if (last_word) begin
      acc_q     <= 1'b0;
      odd_q     <= '0;
      cnt_q     <= '0;
      res_par_q <= acc_q ^ wp ^ ODD_BIT;
      res_cnt_q <= odd_next;
    end else if (take) begin
      acc_q <= acc_q ^ wp;
      odd_q <= odd_next;
      cnt_q <= cnt_q + CW'(1);
    end else if (res_take) begin
      res_par_q <= 1'b0;
      res_cnt_q <= '0;
    end
  end

  assign res_valid   = (state_q == REPORT);
  assign busy        = (state_q != IDLE);
  assign res_parity  = res_par_q;
  assign res_odd_cnt = res_cnt_q;

`ifdef PARIDADE_CHECK_EN
  logic exp_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      exp_q <= 1'b0;
    end else if (last_word) begin
      exp_q <= exp_parity;
    end
  end

  assign res_mismatch = res_valid && (res_par_q ^ exp_q);
`else
  logic unused_exp_parity;
  assign unused_exp_parity = exp_parity;
  assign res_mismatch      = 1'b0;
`endif

endmodule

// File: tb/tb_controle_paridade.sv
module tb_controle_paridade;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned FRAME_LEN = 4;
  localparam int unsigned ODD_MODE  = 0;
  localparam int unsigned CW        = $clog2(FRAME_LEN + 1);

  logic             clk        = 1'b0;
  logic             rst        = 1'b1;
  logic             clear      = 1'b0;
  logic [WIDTH-1:0] in_data    = '0;
  logic             in_valid   = 1'b0;
  logic             in_ready;
  logic             exp_parity = 1'b0;
  logic             res_valid;
  logic             res_ready  = 1'b0;
  logic             res_parity;
  logic [CW-1:0]    res_odd_cnt;
  logic             res_mismatch;
  logic             busy;

  int total = 0;
  int bad   = 0;

  // Reference model: the current frame as a list of words plus a pending result.
  logic [WIDTH-1:0] frame_q[$];
  bit               pend     = 0;
  int               m_par    = 0;
  int               m_cnt    = 0;
  int               m_mis    = 0;

  controle_paridade #(
    .WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN), .ODD_MODE(ODD_MODE)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .exp_parity(exp_parity),
    .res_valid(res_valid), .res_ready(res_ready), .res_parity(res_parity),
    .res_odd_cnt(res_odd_cnt), .res_mismatch(res_mismatch), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic int ones(input logic [WIDTH-1:0] w);
    int n = 0;
    for (int i = 0; i < WIDTH; i++) n += (w[i] === 1'b1) ? 1 : 0;
    return n;
  endfunction

  // One cycle: drive at the falling edge, compare against the model just after,
  // then let the model see the rising edge with the same inputs.
  task automatic cyc(input bit r, input bit c, input bit v, input logic [WIDTH-1:0] d,
                     input bit e, input bit rr);
    bit acc_word;
    int tot_ones;
    int odd_words;
    @(negedge clk);
    rst = r; clear = c; in_valid = v; in_data = d; exp_parity = e; res_ready = rr;
    #1;
    chk("in_ready",  int'(in_ready),  int'(!pend && !c && !r));
    chk("res_valid", int'(res_valid), int'(pend));
    chk("busy",      int'(busy),      int'(pend || frame_q.size() > 0));
    chk("mismatch",  int'(res_mismatch), pend ? m_mis : 0);
    if (pend) begin
      chk("res_parity",  int'(res_parity),  m_par);
      chk("res_odd_cnt", int'(res_odd_cnt), m_cnt);
    end
    @(posedge clk);
    acc_word = !pend && !c && !r && v;
    if (r || c) begin
      frame_q.delete();
      pend = 0;
    end else if (pend) begin
      if (rr) pend = 0;
    end else if (acc_word) begin
      frame_q.push_back(d);
      if (frame_q.size() == FRAME_LEN) begin
        tot_ones  = 0;
        odd_words = 0;
        foreach (frame_q[k]) begin
          tot_ones  += ones(frame_q[k]);
          odd_words += ones(frame_q[k]) % 2;
        end
        m_par = (tot_ones % 2) ^ ODD_MODE;
        m_cnt = odd_words;
`ifdef PARIDADE_CHECK_EN
        m_mis = m_par ^ int'(e);
`else
        m_mis = 0;
`endif
        pend = 1;
        frame_q.delete();
      end
    end
  endtask

  task automatic word(input logic [WIDTH-1:0] d, input bit e, input bit rr);
    cyc(0, 0, 1, d, e, rr);
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, 0, rr);
  endtask

  logic [WIDTH-1:0] fa[4] = '{8'h00, 8'h01, 8'h82, 8'h03};
  logic [WIDTH-1:0] fb[4] = '{8'hAA, 8'h2A, 8'h71, 8'hE3};

  initial begin
    // Reset held for two cycles.
    cyc(1, 0, 0, '0, 0, 0);
    cyc(1, 0, 0, '0, 0, 0);
    chk("rst_par", int'(res_parity), 0);
    chk("rst_cnt", int'(res_odd_cnt), 0);
    chk("rst_rdy", int'(in_ready), 0);

    // Back-to-back frame 00,01,82,03 with res_ready high.
    for (int i = 0; i < 4; i++) word(fa[i], 0, 1);
    #1;
    chk("a_valid", int'(res_valid), 1);
    chk("a_par",   int'(res_parity), 1);
    chk("a_cnt",   int'(res_odd_cnt), 1);
    chk("a_mis",   int'(res_mismatch),
`ifdef PARIDADE_CHECK_EN
        1
`else
        0
`endif
    );
    word(8'h55, 0, 1);   // handshake cycle: word refused
    idle(1, 1);          // bubble back in IDLE

    // Same frame with exp_parity=1.
    for (int i = 0; i < 4; i++) word(fa[i], 1, 0);
    #1;
    chk("a1_mis", int'(res_mismatch), 0);
    idle(1, 1);

    // Frame with two-cycle gaps.
    for (int i = 0; i < 4; i++) begin
      word(fb[i], 0, 0);
      if (i < 3) idle(2, 0);
    end
    #1;
    chk("b_par", int'(res_parity), 0);
    chk("b_cnt", int'(res_odd_cnt), 2);
    // Backpressure with FF offered.
    for (int i = 0; i < 5; i++) word(8'hFF, 0, 0);
    word(8'hFF, 0, 1);
    word(8'hFF, 0, 0);   // taken as word 1 of the next frame
    chk("bp_fill", frame_q.size(), 1);
    word(8'h00, 0, 0);
    word(8'h00, 0, 0);
    word(8'h01, 0, 0);
    #1;
    chk("bp_par", int'(res_parity), 1);
    idle(1, 1);

    // Abort after two words, clear with in_valid high.
    word(8'h01, 0, 1);
    word(8'h01, 0, 1);
    cyc(0, 1, 1, 8'h01, 0, 1);
    word(8'h01, 0, 1);
    word(8'h00, 0, 1);
    word(8'h00, 0, 1);
    word(8'h00, 0, 1);
    #1;
    chk("ab_par", int'(res_parity), 1);
    chk("ab_cnt", int'(res_odd_cnt), 1);
    idle(2, 1);

    // Random traffic, including clear and reset at arbitrary points.
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(99) < 1, $urandom_range(99) < 3, $urandom_range(99) < 70,
          WIDTH'($urandom), 1'($urandom), $urandom_range(99) < 60);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
